// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, owner codes,
// strobe levels and the command bundle passed to the SRAM PHY.
package sram_arbiter_pkg;

    localparam int REG_W = 32;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_MEM
    } owner_t;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sram_phy_ctrl.sv
// SRAM PHY: times one access of WAIT_CYCLES+1 cycles and drives the strobes.
// Ports: start/cmd/addr command in; done/rvalid/rdata out; SRAM pad signals.
module sram_phy_ctrl
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  sram_cmd_t          cmd,
    input  logic [SRAM_AW-1:0] addr,
    output logic               done,
    output logic               rvalid,
    output logic [REG_W-1:0]   rdata,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [REG_W-1:0]   sram_data_o,
    input  logic [REG_W-1:0]   sram_data_i,
    output logic               sram_data_oe_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [SEL_W-1:0]   sram_be_n_o
);

    logic               busy;
    logic [CNT_W-1:0]   cnt;
    sram_cmd_t          cmd_q;
    logic [SRAM_AW-1:0] addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CNT_W'(WAIT_CYCLES);
            cmd_q  <= cmd;
            addr_q <= addr;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done   = busy && (cnt == '0);
    assign rvalid = done && !cmd_q.we;
    assign rdata  = sram_data_i;

    assign sram_addr_o = addr_q;
    assign sram_data_o = cmd_q.wdata;

    // we_n is released in the last cycle so data stays valid past the
    // rising write strobe.
    always_comb begin
        sram_ce_n_o    = STB_OFF;
        sram_oe_n_o    = STB_OFF;
        sram_we_n_o    = STB_OFF;
        sram_be_n_o    = {SEL_W{STB_OFF}};
        sram_data_oe_o = 1'b0;
        if (busy) begin
            sram_ce_n_o = STB_ON;
            sram_be_n_o = ~cmd_q.sel;
            if (cmd_q.we) begin
                sram_data_oe_o = 1'b1;
                if (cnt != '0) begin
                    sram_we_n_o = STB_ON;
                end
            end else begin
                sram_oe_n_o = STB_ON;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the shared SRAM between IF (read-only) and MEM (read/write).
// Ports: IF and MEM request/ack/data, stall request, SRAM pad signals.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_ce_i,
    input  logic [REG_W-1:0]   if_addr_i,
    output logic [REG_W-1:0]   if_data_o,
    output logic               if_ack_o,
    input  logic               mem_ce_i,
    input  logic               mem_we_i,
    input  logic [SEL_W-1:0]   mem_sel_i,
    input  logic [REG_W-1:0]   mem_addr_i,
    input  logic [REG_W-1:0]   mem_data_i,
    output logic [REG_W-1:0]   mem_data_o,
    output logic               mem_ack_o,
    output logic               stall_req_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [REG_W-1:0]   sram_data_o,
    input  logic [REG_W-1:0]   sram_data_i,
    output logic               sram_data_oe_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [SEL_W-1:0]   sram_be_n_o
);

    state_t             state, state_nx;
    owner_t             owner, owner_nx;
    logic               start;
    logic               grant_mem;
    sram_cmd_t          cmd;
    logic [SRAM_AW-1:0] cmd_addr;
    logic               done;
    logic               rvalid;
    logic [REG_W-1:0]   rdata;
    logic               addr_unused;

    assign addr_unused = ^{if_addr_i[REG_W-1:SRAM_AW+2], if_addr_i[1:0],
                           mem_addr_i[REG_W-1:SRAM_AW+2], mem_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    // DONE hands the bus straight to the other side only; the side just
    // acked must pass through IDLE first.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        start     = 1'b0;
        grant_mem = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    start     = 1'b1;
                    grant_mem = 1'b1;
                    owner_nx  = OWN_MEM;
                    state_nx  = ST_ACCESS;
                end else if (if_ce_i) begin
                    start    = 1'b1;
                    owner_nx = OWN_IF;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                owner_nx = OWN_NONE;
                if (owner == OWN_IF && mem_ce_i) begin
                    start     = 1'b1;
                    grant_mem = 1'b1;
                    owner_nx  = OWN_MEM;
                    state_nx  = ST_ACCESS;
                end else if (owner == OWN_MEM && if_ce_i) begin
                    start    = 1'b1;
                    owner_nx = OWN_IF;
                    state_nx = ST_ACCESS;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                owner_nx = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        cmd.we    = grant_mem ? mem_we_i : 1'b0;
        cmd.sel   = grant_mem ? mem_sel_i : {SEL_W{1'b1}};
        cmd.wdata = grant_mem ? mem_data_i : '0;
        cmd_addr  = grant_mem ? mem_addr_i[SRAM_AW+1:2]
                              : if_addr_i[SRAM_AW+1:2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_data_o  <= '0;
            mem_data_o <= '0;
        end else if (rvalid) begin
            if (owner == OWN_IF) begin
                if_data_o <= rdata;
            end
            if (owner == OWN_MEM) begin
                mem_data_o <= rdata;
            end
        end
    end

    assign if_ack_o  = (state == ST_DONE) && (owner == OWN_IF);
    assign mem_ack_o = (state == ST_DONE) && (owner == OWN_MEM);

    assign stall_req_o = (if_ce_i & ~if_ack_o) | (mem_ce_i & ~mem_ack_o);

    sram_phy_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) u_phy (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cmd            (cmd),
        .addr           (cmd_addr),
        .done           (done),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_be_n_o    (sram_be_n_o)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: behavioural SRAM, reference memory,
// directed and randomized accesses, plus a WAIT_CYCLES=1 instance.
module tb_sram_arbiter;

    localparam int W  = 2;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          if_ce = 1'b0;
    logic [31:0]   if_addr = '0;
    logic [31:0]   if_data;
    logic          if_ack;
    logic          mem_ce = 1'b0;
    logic          mem_we = 1'b0;
    logic [3:0]    mem_sel = '0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wd = '0;
    logic [31:0]   mem_data;
    logic          mem_ack;
    logic          stall;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wd;
    logic [31:0]   sram_rd;
    logic          sram_oe;
    logic          ce_n, oe_n, we_n;
    logic [3:0]    be_n;

    sram_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce),
        .if_addr_i      (if_addr),
        .if_data_o      (if_data),
        .if_ack_o       (if_ack),
        .mem_ce_i       (mem_ce),
        .mem_we_i       (mem_we),
        .mem_sel_i      (mem_sel),
        .mem_addr_i     (mem_addr),
        .mem_data_i     (mem_wd),
        .mem_data_o     (mem_data),
        .mem_ack_o      (mem_ack),
        .stall_req_o    (stall),
        .sram_addr_o    (sram_addr),
        .sram_data_o    (sram_wd),
        .sram_data_i    (sram_rd),
        .sram_data_oe_o (sram_oe),
        .sram_ce_n_o    (ce_n),
        .sram_oe_n_o    (oe_n),
        .sram_we_n_o    (we_n),
        .sram_be_n_o    (be_n)
    );

    // second instance built with WAIT_CYCLES=1
    logic          d1_mem_ce = 1'b0;
    logic [31:0]   d1_mem_addr = '0;
    logic [31:0]   d1_if_data, d1_mem_data, d1_sram_wd, d1_sram_rd;
    logic          d1_if_ack, d1_mem_ack, d1_stall, d1_oe;
    logic          d1_ce_n, d1_oe_n, d1_we_n;
    logic [3:0]    d1_be_n;
    logic [AW-1:0] d1_sram_addr;

    assign d1_sram_rd = (d1_sram_addr == AW'(32'h33)) ? 32'hDEAD_BEEF : 32'h0;

    sram_arbiter #(.WAIT_CYCLES(1), .SRAM_AW(AW)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (1'b0),
        .if_addr_i      (32'h0),
        .if_data_o      (d1_if_data),
        .if_ack_o       (d1_if_ack),
        .mem_ce_i       (d1_mem_ce),
        .mem_we_i       (1'b0),
        .mem_sel_i      (4'hF),
        .mem_addr_i     (d1_mem_addr),
        .mem_data_i     (32'h0),
        .mem_data_o     (d1_mem_data),
        .mem_ack_o      (d1_mem_ack),
        .stall_req_o    (d1_stall),
        .sram_addr_o    (d1_sram_addr),
        .sram_data_o    (d1_sram_wd),
        .sram_data_i    (d1_sram_rd),
        .sram_data_oe_o (d1_oe),
        .sram_ce_n_o    (d1_ce_n),
        .sram_oe_n_o    (d1_oe_n),
        .sram_we_n_o    (d1_we_n),
        .sram_be_n_o    (d1_be_n)
    );

    // behavioural SRAM (1K words) and reference copy
    logic [31:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];

    assign sram_rd = sram_mem[sram_addr[9:0]];

    always @(posedge clk) begin
        if (!ce_n && !we_n && sram_oe) begin
            for (int b = 0; b < 4; b++) begin
                if (!be_n[b]) begin
                    sram_mem[sram_addr[9:0]][b*8 +: 8] <= sram_wd[b*8 +: 8];
                end
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_if  = '0;
    logic [31:0] exp_mem = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] idle_pins();
        return {24'b0, ce_n, oe_n, we_n, sram_oe, be_n};
    endfunction

    // One isolated access starting from IDLE; ack expected W+2 negedges
    // after the request is presented.
    task automatic do_access(input bit is_mem, input bit we,
                             input logic [3:0] sel, input logic [9:0] word,
                             input logic [31:0] wd, input bit keep);
        int lat;
        int i;
        bit ack;
        logic [3:0] esel;
        esel = is_mem ? sel : 4'hF;
        @(negedge clk);
        if (is_mem) begin
            mem_ce   = 1'b1;
            mem_we   = we;
            mem_sel  = sel;
            mem_addr = {20'b0, word, 2'b01};
            mem_wd   = wd;
        end else begin
            if_ce   = 1'b1;
            if_addr = {20'b0, word, 2'b00};
        end
        #1;
        chk("stall_req", 32'(stall), 32'd1);
        lat = 0;
        i   = 0;
        while (lat == 0 && i < 20) begin
            @(negedge clk);
            i++;
            ack = is_mem ? mem_ack : if_ack;
            if (ack) begin
                lat = i;
            end else if (i <= W + 1) begin
                chk("strobes", idle_pins(),
                    {24'b0, 1'b0, we, !(we && i <= W), we, ~esel});
                chk("sram_addr", 32'(sram_addr), 32'(word));
                if (we) chk("sram_wdata", sram_wd, wd);
            end
        end
        chk("latency", 32'(lat), 32'(W + 2));
        chk("other_ack", 32'(is_mem ? if_ack : mem_ack), 32'd0);
        chk("done_pins", idle_pins(), 32'h0000_00EF);
        if (we) begin
            ref_mem[word] = merge(ref_mem[word], wd, sel);
        end else if (is_mem) begin
            exp_mem = ref_mem[word];
        end else begin
            exp_if = ref_mem[word];
        end
        chk("if_data", if_data, exp_if);
        chk("mem_data", mem_data, exp_mem);
        if (!keep) begin
            mem_ce = 1'b0;
            if_ce  = 1'b0;
        end
    endtask

    initial begin
        int mt, it, j;
        bit seen;
        for (int k = 0; k < 1024; k++) begin
            sram_mem[k] = $urandom;
            ref_mem[k]  = sram_mem[k];
        end
        sram_mem[4] = 32'h2401_0001;
        ref_mem[4]  = 32'h2401_0001;

        #3;
        chk("rst_pins", idle_pins(), 32'h0000_00EF);
        chk("rst_acks", {30'b0, if_ack, mem_ack}, 32'd0);
        chk("rst_data", if_data | mem_data, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wdata", sram_wd, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // IF read of word 4
        do_access(1'b0, 1'b0, 4'hF, 10'd4, 32'h0, 1'b0);
        chk("if_word4", if_data, 32'h2401_0001);

        // MEM byte write then read back
        do_access(1'b1, 1'b1, 4'b0100, 10'h40, 32'h00AB_0000, 1'b0);
        do_access(1'b1, 1'b0, 4'hF, 10'h40, 32'h0, 1'b0);
        chk("byte_merge", mem_data[23:16], 32'hAB);

        // simultaneous requests: MEM first, IF granted from DONE
        @(negedge clk);
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF;
        mem_addr = {20'b0, 10'd7, 2'b00};
        if_ce = 1'b1; if_addr = {20'b0, 10'd9, 2'b00};
        mt = 0; it = 0; j = 0;
        while (it == 0 && j < 30) begin
            @(negedge clk);
            j++;
            if (mem_ack && mt == 0) begin
                mt = j;
                chk("sim_mem_data", mem_data, ref_mem[7]);
                exp_mem = ref_mem[7];
                mem_ce = 1'b0;
            end
            if (if_ack) begin
                it = j;
                chk("sim_if_data", if_data, ref_mem[9]);
                exp_if = ref_mem[9];
                if_ce = 1'b0;
            end
        end
        chk("sim_mem_lat", 32'(mt), 32'(W + 2));
        chk("sim_if_gap", 32'(it - mt), 32'(W + 2));

        // back-to-back IF: no re-grant from DONE
        do_access(1'b0, 1'b0, 4'hF, 10'd20, 32'h0, 1'b1);
        if_addr = {20'b0, 10'd21, 2'b00};
        it = 0; j = 0;
        while (it == 0 && j < 30) begin
            @(negedge clk);
            j++;
            if (if_ack) it = j;
        end
        chk("b2b_gap", 32'(it), 32'(W + 3));
        chk("b2b_data", if_data, ref_mem[21]);
        exp_if = ref_mem[21];
        if_ce = 1'b0;

        // reset during the second ACCESS cycle
        @(negedge clk);
        @(negedge clk);
        if_ce = 1'b1; if_addr = {20'b0, 10'd30, 2'b00};
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_ce", 32'(ce_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_pins", idle_pins(), 32'h0000_00EF);
        chk("rst_mid_data", if_data | mem_data, 32'd0);
        exp_if = '0; exp_mem = '0;
        if_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if_ack || mem_ack || stall || !ce_n) seen = 1'b1;
        end
        chk("rst_no_ack", 32'(seen), 32'd0);

        // randomized isolated accesses, including sel=0 writes
        for (int n = 0; n < 40; n++) begin
            bit m, w;
            logic [3:0] s;
            m = 1'($urandom_range(0, 1));
            w = m ? 1'($urandom_range(0, 1)) : 1'b0;
            s = (n % 10 == 3) ? 4'h0 : 4'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_access(m, w, s, 10'($urandom_range(0, 31)), $urandom, 1'b0);
        end

        // WAIT_CYCLES=1 instance: read acks 3 cycles after the request
        @(negedge clk);
        d1_mem_ce = 1'b1;
        d1_mem_addr = {20'b0, 10'h33, 2'b00};
        mt = 0; j = 0;
        while (mt == 0 && j < 20) begin
            @(negedge clk);
            j++;
            if (d1_mem_ack) mt = j;
        end
        d1_mem_ce = 1'b0;
        chk("w1_lat", 32'(mt), 32'd3);
        chk("w1_data", d1_mem_data, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
